// File: rtl/instr_loader.sv
// Instruction memory loader: streams a program of load_len words into the
// instruction memory while holding the core in reset, then releases it.
module instr_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   checksum
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic [1:0]    state_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   len_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   csum_reg;
    logic          err_reg;
    logic          done_reg;

    logic len_ok;
    logic can_start;
    logic hs;

    assign len_ok    = (load_len != '0) && (load_len <= (AW+1)'(DEPTH));
    assign can_start = (state_reg == IDLE) || (state_reg == RUN);
    assign hs        = in_valid && (state_reg == LOAD);

    assign in_ready   = (state_reg == LOAD);
    assign busy       = (state_reg == LOAD) || (state_reg == FLUSH);
    assign core_reset = (state_reg != RUN);
    assign done       = done_reg;
    assign err        = err_reg;
    assign checksum   = csum_reg;
    assign im_we      = we_reg;
    assign im_addr    = addr_reg;
    assign im_wdata   = wdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            len_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            csum_reg  <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            we_reg   <= hs;
            done_reg <= 1'b0;

            if (hs) begin
                addr_reg  <= count_reg[AW-1:0];
                wdata_reg <= in_data;
                count_reg <= count_reg + (AW+1)'(1);
                csum_reg  <= csum_reg ^ in_data;
                if (count_reg == len_reg - (AW+1)'(1))
                    state_reg <= FLUSH;
            end

            // FLUSH covers the cycle in which the last word is being written
            if (state_reg == FLUSH) begin
                state_reg <= RUN;
                done_reg  <= 1'b1;
            end

            // Requests during LOAD/FLUSH are deliberately ignored
            if (can_start && load_start) begin
                if (len_ok) begin
                    state_reg <= LOAD;
                    count_reg <= '0;
                    csum_reg  <= '0;
                    err_reg   <= 1'b0;
                    len_reg   <= load_len;
                end else begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader with a transaction-level
// model: expected writes are the accepted words at addresses 0..len-1.
module tb_instr_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   checksum;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] wq[$];

    instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .err(err),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (im_we === 1'b1) wq.push_back({im_addr, im_wdata});

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one load. pat (if long enough) fixes in_valid per cycle, else
    // valid is random with probability pct. inject>=0 pulses a stray
    // load_start of length 3 at that cycle.
    task automatic run_load(input int len, input int pct, input bit pat[$],
                            input int inject, input logic [31:0] first_w,
                            input logic [31:0] last_w, input bit fixed_ends,
                            input string tag);
        logic [31:0] words[$];
        logic [31:0] x;
        logic [31:0] w;
        int sent;
        int cyc;
        bit hs;
        x = '0;
        sent = 0;
        cyc = 0;
        wq.delete();
        load_len = (AW+1)'(len);
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        checks++;
        if (core_reset !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL %s start: core_reset=%b busy=%b err=%b csum=%h required 1 1 0 0",
                     tag, core_reset, busy, err, checksum);
        end
        while (sent < len && cyc < 2000) begin
            w = $urandom;
            if (fixed_ends && sent == 0) w = first_w;
            if (fixed_ends && sent == len - 1) w = last_w;
            in_data = w;
            in_valid = (cyc < pat.size()) ? pat[cyc] : ($urandom_range(99) < pct);
            load_start = (cyc == inject);
            load_len = (cyc == inject) ? (AW+1)'(3) : (AW+1)'(len);
            hs = in_valid;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s in_ready cyc %0d: got %b required 1", tag, cyc, in_ready);
            end
            if (hs) begin
                words.push_back(w);
                x ^= w;
                sent++;
            end
            tick;
            cyc++;
            load_start = 1'b0;
            checks++;
            if (im_we !== hs || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s we/busy cyc %0d: im_we=%b busy=%b required %b 1",
                         tag, cyc, im_we, busy, hs);
            end
        end
        in_valid = 1'b0;
        if (sent < len) begin
            errors++;
            $display("FAIL %s timeout: sent %0d required %0d", tag, sent, len);
        end
        checks++;
        if (core_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s flush: core_reset=%b done=%b in_ready=%b required 1 0 0",
                     tag, core_reset, done, in_ready);
        end
        tick;
        checks++;
        if (core_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s run entry: core_reset=%b done=%b busy=%b required 0 1 0",
                     tag, core_reset, done, busy);
        end
        tick;
        checks++;
        if (done !== 1'b0 || core_reset !== 1'b0 || im_we !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse: done=%b core_reset=%b im_we=%b required 0 0 0",
                     tag, done, core_reset, im_we);
        end
        checks++;
        if (wq.size() != len) begin
            errors++;
            $display("FAIL %s write count: got %0d required %0d", tag, wq.size(), len);
        end
        for (int i = 0; i < len && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== {i[AW-1:0], words[i]}) begin
                errors++;
                $display("FAIL %s write %0d: got addr %0d data %h required addr %0d data %h",
                         tag, i, wq[i][AW+31:32], wq[i][31:0], i, words[i]);
            end
        end
        checks++;
        if (checksum !== x || err !== 1'b0) begin
            errors++;
            $display("FAIL %s checksum/err: got %h err %b required %h err 0", tag, checksum, err, x);
        end
        $display("load %s len=%0d cycles=%0d checksum=%h", tag, len, cyc, x);
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bit none[$];
        load_start = 1'b1;
        load_len = 7'd5;
        in_valid = 1'b1;
        in_data = 32'hdeadbeef;
        apply_reset;
        load_start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (core_reset !== 1'b1 || in_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== '0 ||
            im_wdata !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset: cr=%b rdy=%b we=%b addr=%0d wd=%h busy=%b done=%b err=%b cs=%h required 1 0 0 0 0 0 0 0 0",
                     core_reset, in_ready, im_we, im_addr, im_wdata, busy, done, err, checksum);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset idle hold: busy=%b core_reset=%b required 0 1", busy, core_reset);
        end
        $display("reset checked");
    endtask

    task automatic test_back_to_back;
        bit all1[$];
        for (int i = 0; i < 10; i++) all1.push_back(1'b1);
        run_load(10, 100, all1, -1, 32'h00222800, 32'h15450006, 1'b1, "back_to_back");
    endtask

    task automatic test_gaps;
        bit pat[$];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_load(4, 50, pat, -1, 32'h0, 32'h0, 1'b0, "gaps");
    endtask

    task automatic test_bad_len;
        bit none[$];
        int lens[2];
        lens = '{0, 65};
        apply_reset;
        foreach (lens[k]) begin
            wq.delete();
            load_len = (AW+1)'(lens[k]);
            load_start = 1'b1;
            tick;
            load_start = 1'b0;
            tick;
            checks++;
            if (err !== 1'b1 || core_reset !== 1'b1 || busy !== 1'b0 || wq.size() != 0) begin
                errors++;
                $display("FAIL bad_len %0d: err=%b core_reset=%b busy=%b writes=%0d required 1 1 0 0",
                         lens[k], err, core_reset, busy, wq.size());
            end
            $display("bad load_len=%0d err=%b", lens[k], err);
        end
        run_load(3, 60, none, -1, 32'h0, 32'h0, 1'b0, "after_err");
    endtask

    task automatic test_reset_mid_load;
        bit none[$];
        wq.delete();
        load_len = 7'd8;
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            tick;
        end
        reset = 1'b1;
        in_data = $urandom;
        tick;
        reset = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (im_we !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 ||
            checksum !== 32'h0) begin
            errors++;
            $display("FAIL mid_load reset: we=%b cr=%b busy=%b rdy=%b cs=%h required 0 1 0 0 0",
                     im_we, core_reset, busy, in_ready, checksum);
        end
        $display("reset after 3 of 8 handshakes");
        run_load(8, 70, none, -1, 32'h0, 32'h0, 1'b0, "reload8");
    endtask

    task automatic test_run_reload;
        bit none[$];
        run_load(2, 100, none, -1, 32'h0, 32'h0, 1'b0, "run_reload");
    endtask

    task automatic test_ignore_start;
        bit none[$];
        run_load(5, 80, none, 2, 32'h0, 32'h0, 1'b0, "ignore_start");
    endtask

    task automatic test_random;
        bit none[$];
        for (int n = 0; n < 6; n++)
            run_load($urandom_range(DEPTH, 1), $urandom_range(90, 30), none, -1,
                     32'h0, 32'h0, 1'b0, "random");
        run_load(DEPTH, 75, none, -1, 32'h0, 32'h0, 1'b0, "full_depth");
    endtask

    initial begin
        reset = 1'b0;
        load_start = 1'b0;
        load_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        test_reset;
        test_back_to_back;
        test_gaps;
        test_bad_len;
        test_reset_mid_load;
        test_run_reload;
        test_ignore_start;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
